// File: rtl/usb_tx_encoder.sv
// ----------------------------------------------------------------------------
// usb_tx_encoder
//   Drives the USB line during transmission. It NRZI-encodes the serial data
//   bits: a 0 toggles the line between J and K, and a 1 holds it. After six
//   consecutive 1s it inserts a stuffed toggle. When the data ends it closes
//   the packet with the end-of-packet sequence: SE0, SE0, then J.
//
// Ports
//   clk        in   system clock, rising-edge active
//   n_rst      in   synchronous reset, active-high (1 = reset)
//   tx_start   in   packet request, sampled only in IDLE
//   serial_in  in   current data bit from the transmit shift register
//   new_bit    in   one-cycle bit-period strobe from the USB timer
//   EOD        in   end-of-data strobe from the timer byte counter
//   bit_sent   out  combinational: data bit consumed this cycle
//   Tim_rst    out  one-cycle timer clear (START state)
//   Tim_en     out  timer width-counter enable (all states but IDLE/START)
//   d_plus     out  registered D+ line drive
//   d_minus    out  registered D- line drive
//   tx_busy    out  high whenever not IDLE
//   tx_done    out  one-cycle pulse on return to IDLE after EOP
// ----------------------------------------------------------------------------
module usb_tx_encoder (
    input  logic clk,
    input  logic n_rst,
    input  logic tx_start,
    input  logic serial_in,
    input  logic new_bit,
    input  logic EOD,
    output logic bit_sent,
    output logic Tim_rst,
    output logic Tim_en,
    output logic d_plus,
    output logic d_minus,
    output logic tx_busy,
    output logic tx_done
);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STUFF, SE0_1, SE0_2, EOP_J
    } state_t;

    state_t      state_q, state_d;
    logic        dp_q, dp_d;
    logic        dm_q, dm_d;
    logic [2:0]  ones_q, ones_d;
    logic        eod_q, eod_d;
    logic        done_q, done_d;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q <= IDLE;
            dp_q    <= 1'b1;
            dm_q    <= 1'b0;
            ones_q  <= 3'd0;
            eod_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dp_q    <= dp_d;
            dm_q    <= dm_d;
            ones_q  <= ones_d;
            eod_q   <= eod_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dp_d     = dp_q;
        dm_d     = dm_q;
        ones_d   = ones_q;
        eod_d    = eod_q;
        done_d   = 1'b0;
        bit_sent = 1'b0;

        // EOD is remembered until the next packet start, so an EOD strobe
        // landing mid-bit or during a stuffed bit is not lost.
        if (EOD && (state_q != IDLE) && (state_q != START))
            eod_d = 1'b1;

        case (state_q)
            IDLE: begin
                dp_d = 1'b1;
                dm_d = 1'b0;
                if (tx_start)
                    state_d = START;
            end
            START: begin
                dp_d    = 1'b1;
                dm_d    = 1'b0;
                ones_d  = 3'd0;
                eod_d   = 1'b0;
                state_d = DATA;
            end
            DATA: begin
                if (new_bit) begin
                    if (eod_q) begin
                        // The pending EOD takes this bit slot for the first SE0.
                        dp_d    = 1'b0;
                        dm_d    = 1'b0;
                        state_d = SE0_1;
                    end else begin
                        bit_sent = 1'b1;
                        if (!serial_in) begin
                            dp_d   = ~dp_q;
                            dm_d   = ~dm_q;
                            ones_d = 3'd0;
                        end else begin
                            ones_d = ones_q + 3'd1;
                            // This 1 is the sixth in a row, so the next slot is a stuffed bit.
                            if (ones_q == 3'd5)
                                state_d = STUFF;
                        end
                    end
                end
            end
            STUFF: begin
                if (new_bit) begin
                    dp_d    = ~dp_q;
                    dm_d    = ~dm_q;
                    ones_d  = 3'd0;
                    state_d = DATA;
                end
            end
            SE0_1: begin
                if (new_bit)
                    state_d = SE0_2;
            end
            SE0_2: begin
                if (new_bit) begin
                    dp_d    = 1'b1;
                    dm_d    = 1'b0;
                    state_d = EOP_J;
                end
            end
            EOP_J: begin
                if (new_bit) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Tim_rst = (state_q == START);
    assign Tim_en  = (state_q != IDLE) && (state_q != START);
    assign tx_busy = (state_q != IDLE);
    assign tx_done = done_q;
    assign d_plus  = dp_q;
    assign d_minus = dm_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
module tb_usb_tx_encoder;

    logic clk = 1'b0;
    logic n_rst, tx_start, serial_in, new_bit, EOD;
    logic bit_sent, Tim_rst, Tim_en, d_plus, d_minus, tx_busy, tx_done;

    localparam logic [1:0] LJ  = 2'b10;
    localparam logic [1:0] LK  = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    int n_chk  = 0;
    int n_pass = 0;
    int sent_cnt = 0;
    int trst_cnt = 0;
    int done_cnt = 0;

    usb_tx_encoder dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .tx_start (tx_start),
        .serial_in(serial_in),
        .new_bit  (new_bit),
        .EOD      (EOD),
        .bit_sent (bit_sent),
        .Tim_rst  (Tim_rst),
        .Tim_en   (Tim_en),
        .d_plus   (d_plus),
        .d_minus  (d_minus),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bit_sent) sent_cnt++;
        if (Tim_rst)  trst_cnt++;
        if (tx_done)  done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Called at posedge+1. Presents one bit-period strobe, returns bit_sent
    // seen in that cycle, then idles 7 more cycles (new_bit every 8 cycles).
    task automatic nb(input logic sin, input logic eod, output logic sent);
        serial_in = sin;
        EOD       = eod;
        new_bit   = 1'b1;
        @(negedge clk);
        sent = bit_sent;
        @(posedge clk); #1;
        new_bit = 1'b0;
        EOD     = 1'b0;
        repeat (7) @(posedge clk);
        #1;
    endtask

    task automatic start_pkt(input string tag);
        int r0;
        r0 = trst_cnt;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        chk({tag, "_timrst"}, Tim_rst, 1);
        chk({tag, "_timen_start"}, Tim_en, 0);
        chk({tag, "_busy_start"}, tx_busy, 1);
        @(posedge clk); #1;
        chk({tag, "_timrst_cnt"}, trst_cnt - r0, 1);
        chk({tag, "_timen_data"}, Tim_en, 1);
        chk({tag, "_line_first"}, {d_plus, d_minus}, LJ);
    endtask

    task automatic eod_pulse();
        EOD = 1'b1;
        @(posedge clk); #1;
        EOD = 1'b0;
    endtask

    initial begin
        logic s;
        logic [1:0] exp_line;
        int s0, d0, r0;
        n_rst = 1'b1; tx_start = 1'b0; serial_in = 1'b0; new_bit = 1'b0; EOD = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b0;

        // Reset state
        chk("rst_line", {d_plus, d_minus}, LJ);
        chk("rst_busy", tx_busy, 0);
        chk("rst_timen", Tim_en, 0);
        chk("rst_timrst", Tim_rst, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_sent", bit_sent, 0);
        repeat (3) @(posedge clk);
        #1;

        // Packet A: eight zeros alternate K,J,K,J,...
        start_pkt("A");
        s0 = sent_cnt;
        exp_line = LJ;
        for (int i = 0; i < 8; i++) begin
            nb(1'b0, 1'b0, s);
            exp_line = ~exp_line;
            chk($sformatf("A_sent%0d", i), s, 1);
            chk($sformatf("A_line%0d", i), {d_plus, d_minus}, exp_line);
        end
        chk("A_sent_cnt8", sent_cnt - s0, 8);

        // tx_start while busy is ignored
        r0 = trst_cnt;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        @(posedge clk); #1;
        chk("A_start_ign_rst", trst_cnt - r0, 0);
        chk("A_start_ign_busy", tx_busy, 1);
        chk("A_start_ign_line", {d_plus, d_minus}, LJ);

        // EOD with new_bit in the same cycle: this bit still goes out
        nb(1'b0, 1'b1, s);
        chk("A_eod_same_sent", s, 1);
        chk("A_eod_same_line", {d_plus, d_minus}, LK);
        nb(1'b1, 1'b0, s);
        chk("A_se0a_sent", s, 0);
        chk("A_se0a_line", {d_plus, d_minus}, SE0);
        nb(1'b1, 1'b0, s);
        chk("A_se0b_line", {d_plus, d_minus}, SE0);
        d0 = done_cnt;
        nb(1'b1, 1'b0, s);
        chk("A_eopj_line", {d_plus, d_minus}, LJ);
        chk("A_eopj_busy", tx_busy, 1);
        chk("A_eopj_done_early", done_cnt - d0, 0);
        nb(1'b1, 1'b0, s);
        chk("A_done_cnt", done_cnt - d0, 1);
        chk("A_end_busy", tx_busy, 0);
        chk("A_end_timen", Tim_en, 0);
        chk("A_end_line", {d_plus, d_minus}, LJ);
        chk("A_total_sent", sent_cnt - s0, 9);

        // Packet B: seven ones -> stuffed K, then EOD during a second STUFF
        start_pkt("B");
        s0 = sent_cnt;
        for (int i = 0; i < 6; i++) begin
            nb(1'b1, 1'b0, s);
            chk($sformatf("B_sent%0d", i), s, 1);
            chk($sformatf("B_line%0d", i), {d_plus, d_minus}, LJ);
        end
        nb(1'b1, 1'b0, s);
        chk("B_stuff_sent", s, 0);
        chk("B_stuff_line", {d_plus, d_minus}, LK);
        nb(1'b1, 1'b0, s);
        chk("B_bit7_sent", s, 1);
        chk("B_bit7_line", {d_plus, d_minus}, LK);
        // Five more ones reach six in a row again
        for (int i = 0; i < 5; i++) begin
            nb(1'b1, 1'b0, s);
            chk($sformatf("B2_line%0d", i), {d_plus, d_minus}, LK);
        end
        eod_pulse();
        nb(1'b0, 1'b0, s);
        chk("B_eodstuff_sent", s, 0);
        chk("B_eodstuff_line", {d_plus, d_minus}, LJ);
        nb(1'b0, 1'b0, s);
        chk("B_se0_line", {d_plus, d_minus}, SE0);
        nb(1'b0, 1'b0, s);
        nb(1'b0, 1'b0, s);
        chk("B_eopj_line", {d_plus, d_minus}, LJ);
        d0 = done_cnt;
        nb(1'b0, 1'b0, s);
        chk("B_done", done_cnt - d0, 1);
        chk("B_sent_cnt12", sent_cnt - s0, 12);

        // Packet C: reset during SE0_1 aborts cleanly
        start_pkt("C");
        nb(1'b0, 1'b0, s);
        chk("C_line0", {d_plus, d_minus}, LK);
        eod_pulse();
        nb(1'b0, 1'b0, s);
        chk("C_se0_line", {d_plus, d_minus}, SE0);
        d0 = done_cnt;
        n_rst = 1'b1;
        @(posedge clk); #1;
        n_rst = 1'b0;
        chk("C_rst_line", {d_plus, d_minus}, LJ);
        chk("C_rst_busy", tx_busy, 0);
        chk("C_rst_timen", Tim_en, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("C_rst_nodone", done_cnt - d0, 0);

        start_pkt("D");
        nb(1'b0, 1'b0, s);
        chk("D_sent0", s, 1);
        chk("D_line0", {d_plus, d_minus}, LK);
        nb(1'b1, 1'b0, s);
        chk("D_sent1", s, 1);
        chk("D_line1", {d_plus, d_minus}, LK);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
